tensor_core_sequencer: RTL

TENSOR_CORE_SEQUENCER -- requirements
Module: tensor_core_sequencer

---
 rtl/tensor_core_sequencer_pkg.sv | 20 ++
 rtl/tensor_core_sequencer_matrix_byte_packer.sv | 23 ++
 rtl/tensor_core_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/tensor_core_sequencer_pkg.sv
// Shared types and sizing for the tensor core load/start/unload sequencer.
package tensor_core_sequencer_pkg;

   localparam int MATRIX_BITS            = 64;
   localparam int ELEM_BITS              = 4;
   localparam int BYTE_BITS              = 8;
   localparam int BYTES_PER_MATRIX       = 8;
   localparam int TIMEOUT_CYCLES_DEFAULT = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_A = 3'd1,
      ST_LOAD_B = 3'd2,
      ST_START  = 3'd3,
      ST_SETTLE = 3'd4,
      ST_WAIT   = 3'd5,
      ST_UNLOAD = 3'd6
   } state_e;

endpackage

// File: rtl/tensor_core_sequencer_matrix_byte_packer.sv
// Byte <-> 64-bit matrix packing. Byte k lives at bits [63-8k:56-8k], so the
// bit offset of byte k is 8*(7-k), which for a 3-bit k is simply {~k, 3'b000}.
module matrix_byte_packer
   import tensor_core_sequencer_pkg::*;
(
   input  logic [MATRIX_BITS-1:0] pack_matrix_i,
   input  logic [2:0]             pack_idx_i,
   input  logic [BYTE_BITS-1:0]   pack_byte_i,
   output logic [MATRIX_BITS-1:0] pack_matrix_o,
   input  logic [MATRIX_BITS-1:0] unpack_matrix_i,
   input  logic [2:0]             unpack_idx_i,
   output logic [BYTE_BITS-1:0]   unpack_byte_o
);

   // Overwrite one byte of the matrix, leaving the other seven untouched.
   always_comb begin
      pack_matrix_o = pack_matrix_i;
      pack_matrix_o[{~pack_idx_i, 3'b000} +: BYTE_BITS] = pack_byte_i;
   end

   assign unpack_byte_o = unpack_matrix_i[{~unpack_idx_i, 3'b000} +: BYTE_BITS];

endmodule

// File: rtl/tensor_core_sequencer.sv
// Streams two 4x4 nibble matrices into a tensor core, kicks it off, waits for
// completion (with timeout) and streams the product back out byte by byte.
//
// state  | meaning
// IDLE   | waiting for first operand byte
// LOAD_A | receiving bytes 1..7 of matrix A
// LOAD_B | receiving bytes 8..15 (matrix B)
// START  | one-cycle write_enable pulse to the core
// SETTLE | one cycle where done is ignored (masks stale done)
// WAIT   | waiting for done, timer counting down
// UNLOAD | presenting result bytes 0..7
module tensor_core_sequencer
   import tensor_core_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic                   clock_in,
   input  logic                   reset_in,
   input  logic [BYTE_BITS-1:0]   in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [BYTE_BITS-1:0]   out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   tensor_core_register_file_write_enable,
   output logic [MATRIX_BITS-1:0] tensor_core_input1,
   output logic [MATRIX_BITS-1:0] tensor_core_input2,
   input  logic [MATRIX_BITS-1:0] tensor_core_output,
   input  logic                   is_done_with_calculation,
   output logic                   busy,
   output logic                   timeout_error
);

   localparam int TMR_BITS = $clog2(TIMEOUT_CYCLES + 1);

   state_e                 state_q;
   logic [3:0]             byte_cnt_q;
   logic [2:0]             out_idx_q;
   logic [TMR_BITS-1:0]    tmr_q;
   logic [MATRIX_BITS-1:0] mat_a_q;
   logic [MATRIX_BITS-1:0] mat_b_q;
   logic [MATRIX_BITS-1:0] result_q;
   logic                   we_q;
   logic                   out_valid_q;
   logic                   busy_q;
   logic                   timeout_q;

   logic                   in_fire;
   logic [MATRIX_BITS-1:0] packed_d;

   assign in_ready = !reset_in &&
                     (state_q == ST_IDLE || state_q == ST_LOAD_A || state_q == ST_LOAD_B);
   assign in_fire  = in_valid && in_ready;

   // Counter bit 3 selects which matrix the incoming byte lands in.
   matrix_byte_packer u_packer (
      .pack_matrix_i   (byte_cnt_q[3] ? mat_b_q : mat_a_q),
      .pack_idx_i      (byte_cnt_q[2:0]),
      .pack_byte_i     (in_data),
      .pack_matrix_o   (packed_d),
      .unpack_matrix_i (result_q),
      .unpack_idx_i    (out_idx_q),
      .unpack_byte_o   (out_data)
   );

   // Sequencer FSM with its counters, data registers and registered outputs.
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         state_q     <= ST_IDLE;
         byte_cnt_q  <= '0;
         out_idx_q   <= '0;
         tmr_q       <= '0;
         mat_a_q     <= '0;
         mat_b_q     <= '0;
         result_q    <= '0;
         we_q        <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         we_q <= 1'b0;
         if (in_fire) begin
            if (byte_cnt_q[3]) mat_b_q <= packed_d;
            else               mat_a_q <= packed_d;
            byte_cnt_q <= byte_cnt_q + 4'd1;
         end
         case (state_q)
            ST_IDLE: begin
               if (in_fire) begin
                  state_q <= ST_LOAD_A;
                  busy_q  <= 1'b1;
               end
            end
            ST_LOAD_A: begin
               if (in_fire && byte_cnt_q == 4'd7) state_q <= ST_LOAD_B;
            end
            ST_LOAD_B: begin
               if (in_fire && byte_cnt_q == 4'd15) begin
                  state_q <= ST_START;
                  we_q    <= 1'b1;
               end
            end
            ST_START: state_q <= ST_SETTLE;
            ST_SETTLE: begin
               state_q <= ST_WAIT;
               tmr_q   <= TMR_BITS'(TIMEOUT_CYCLES);
            end
            ST_WAIT: begin
               if (is_done_with_calculation) begin
                  result_q    <= tensor_core_output;
                  state_q     <= ST_UNLOAD;
                  out_valid_q <= 1'b1;
               end else if (tmr_q == TMR_BITS'(1)) begin
                  timeout_q <= 1'b1;
                  state_q   <= ST_IDLE;
                  busy_q    <= 1'b0;
               end else begin
                  tmr_q <= tmr_q - TMR_BITS'(1);
               end
            end
            ST_UNLOAD: begin
               if (out_ready) begin
                  out_idx_q <= out_idx_q + 3'd1;
                  if (out_idx_q == 3'd7) begin
                     state_q     <= ST_IDLE;
                     out_valid_q <= 1'b0;
                     busy_q      <= 1'b0;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign out_valid                              = out_valid_q;
   assign tensor_core_register_file_write_enable = we_q;
   assign tensor_core_input1                     = mat_a_q;
   assign tensor_core_input2                     = mat_b_q;
   assign busy                                   = busy_q;
   assign timeout_error                          = timeout_q;

endmodule
